alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised successor to the single-cycle execute ALU.
- Covers the full RV32I/M integer op set (base ALU, multiply, optional divide) at configurable WIDTH.
- Uses a valid/ready handshake with variable latency: 1 cycle for base ops, MUL_STAGES for multiply, WIDTH+2 for divide.
- Sits in EX between the operand-forwarding mux and the EX/MEM register; the core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width (≥8, even).
- MUL_STAGES, 3, multiplier pipeline depth in cycles (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- alu_op  in  5  operation code (alu_pkg).
- operand1  in  WIDTH  rs1 value.
- operand2  in  WIDTH  rs2/imm value; shift amount = operand2[$clog2(WIDTH)-1:0].
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts result.
- alu_result  out  WIDTH  result.
- zero  out  1  alu_result == 0.
- negative  out  1  alu_result[WIDTH-1].
- overflow  out  1  signed overflow (ADD/SUB only, else 0).
- carry  out  1  ADD: carry-out; SUB: borrow (operand1 <u operand2); else 0.
- illegal  out  1  unknown alu_op.

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0 except in_ready, which is 1.
- Reset mid-operation aborts any MUL/DIV in flight; no out_valid follows the abort.
- FSM states: IDLE, MUL, DIV, DONE.
  - Accept = in_valid && in_ready. Operands and op are registered on accept.
  - in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back ops are allowed: a new accept in DONE coincides with the old result's handshake.
- Base ops: IDLE/DONE→DONE; result registered on the accept edge, so out_valid rises the next cycle.
- MUL ops: →MUL; counter runs MUL_STAGES cycles; →DONE. out_valid asserts exactly MUL_STAGES cycles after accept.
- DIV ops (feature enabled): →DIV; restoring divider runs WIDTH iterations plus 1 sign-fix cycle; →DONE. out_valid asserts WIDTH+2 cycles after accept.
- DONE: result and flags stay stable while out_valid && !out_ready.
  - out_ready with no new accept → IDLE.
  - out_ready with a new accept → next state per the new op.
- Op semantics follow RISC-V:
  - SLT/SLTU return 0/1.
  - SRA is arithmetic.
  - MULH/MULHSU/MULHU return the upper WIDTH bits of the 2·WIDTH product; MUL returns the lower WIDTH bits.
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → operand1.
  - Signed overflow (MIN / −1): DIV → MIN; REM → 0. The overflow flag stays 0 for divides.
- Unknown op: 1-cycle path, alu_result=0, illegal=1, zero=1.
- Flags are computed from the final result and registered with it. There is no same-cycle read-after-write hazard.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined: DIV/DIVU/REM/REMU run the iterative divider as described above.
- Undefined: the divider and DIV state are not built; divide opcodes are treated as unknown (illegal=1, result 0, 1 cycle).

Decomposition:
- Package alu_pkg holds:
  - alu_op_t, a 5-bit enum: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, MUL=10, MULH=11, MULHSU=12, MULHU=13, DIV=14, DIVU=15, REM=16, REMU=17.
  - alu_state_t.
  - Helper functions is_mul(op) and is_div(op).
- One sub-module, alu_mul_pipe(WIDTH, MUL_STAGES): signed/unsigned-extended (WIDTH+1)×(WIDTH+1) product, shift-register pipelined, with a valid pipe. The divider stays inline.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001, out_ready=1 → 1 cycle later alu_result=0x80000000, overflow=1, negative=1, carry=0.
- SUB 5−7 → alu_result=0xFFFFFFFE, carry=1, negative=1; SUB 3−3 → alu_result=0, zero=1.
- MULH 0x80000000×0x80000000 → out_valid exactly 3 cycles after accept, alu_result=0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- Hold out_ready=0 for 5 cycles after SRA 0x80000000>>4 → alu_result holds 0xF8000000, in_ready=0. Release out_ready with an SLTU 1<0xFFFFFFFF pending → accepted in the same cycle, next result 1.
- ALU_DIV_EN defined:
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 after 34 cycles.
  - DIVU 7/0 → 0xFFFFFFFF.
  - REM −7/2 → 0xFFFFFFFF.
  - Assert rst at cycle 10 of a divide → no out_valid, in_ready=1 next cycle.
- alu_op=31 → illegal=1, alu_result=0, zero=1. With ALU_DIV_EN undefined, DIV gives the same response.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the pipelined execute ALU: opcode and FSM state
// enums plus opcode class helpers.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_t;

  function automatic logic is_mul(input alu_op_t op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
  endfunction

  function automatic logic is_div(input alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_mul_pipe.sv
// Multiplier for alu_pipe: operands are sign- or zero-extended to WIDTH+1
// bits so one signed product covers MUL/MULH/MULHSU/MULHU. The product is
// formed combinationally from the accept-cycle operands and then delayed
// through MUL_STAGES-1 registers, so the caller registers it on the
// MUL_STAGES-th edge after accept.
module alu_mul_pipe #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             a_signed,
  input  logic             b_signed,
  input  logic             hi,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH:0]       a_x, b_x;
  logic [2*WIDTH-1:0]   a_e, b_e, prod;

  assign a_x  = {a_signed & a[WIDTH-1], a};
  assign b_x  = {b_signed & b[WIDTH-1], b};
  // Low 2*WIDTH bits of the extended product are exact for every signedness mix.
  assign a_e  = {{(WIDTH-1){a_x[WIDTH]}}, a_x};
  assign b_e  = {{(WIDTH-1){b_x[WIDTH]}}, b_x};
  assign prod = a_e * b_e;

  generate
    if (MUL_STAGES == 1) begin : g_comb
      assign out_valid = in_valid;
      assign result    = hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    end else begin : g_pipe
      logic [2*WIDTH-1:0]  prod_sr [MUL_STAGES-1];
      logic [MUL_STAGES-2:0] vld_sr;
      logic [MUL_STAGES-2:0] hi_sr;

      // Valid pipe; cleared by reset so an aborted multiply never completes.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_sr <= '0;
        end else begin
          vld_sr[0] <= in_valid;
          for (int i = 1; i < MUL_STAGES - 1; i++) vld_sr[i] <= vld_sr[i-1];
        end
      end

      // Product and half-select shift register.
      always_ff @(posedge clk) begin
        prod_sr[0] <= prod;
        hi_sr[0]   <= hi;
        for (int i = 1; i < MUL_STAGES - 1; i++) begin
          prod_sr[i] <= prod_sr[i-1];
          hi_sr[i]   <= hi_sr[i-1];
        end
      end

      assign out_valid = vld_sr[MUL_STAGES-2];
      assign result    = hi_sr[MUL_STAGES-2] ? prod_sr[MUL_STAGES-2][2*WIDTH-1:WIDTH]
                                             : prod_sr[MUL_STAGES-2][WIDTH-1:0];
    end
  endgenerate

endmodule

// File: rtl/alu_pipe.sv
// Variable-latency execute ALU with valid/ready handshake.
// Base ops take 1 cycle, multiplies MUL_STAGES, divides WIDTH+2.
// Build macro ALU_DIV_EN adds the iterative divider; without it the
// divide opcodes are reported as illegal.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | no result held, ready for a request
// MUL     | waiting for the multiplier pipe to drain
// DIV     | restoring divider iterating / final sign fix
// DONE    | result held valid until out_ready
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             carry,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state, state_nx;
  alu_op_t          op_in;
  logic             accept, go_mul, go_div;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic [WIDTH-1:0] base_res;
  logic             base_ovf, base_carry, base_ill;
  logic             mul_valid;
  logic [WIDTH-1:0] mul_res;
  logic             div_done;
  logic [WIDTH-1:0] div_res;
  logic             load_res;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d, carry_d, ill_d;

  assign op_in     = alu_op_t'(alu_op);
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign go_mul    = accept && is_mul(op_in);
  assign shamt     = operand2[SHW-1:0];
  assign add_sum   = {1'b0, operand1} + {1'b0, operand2};
  assign sub_diff  = operand1 - operand2;

  // Single-cycle ops; anything not handled here is flagged illegal.
  always_comb begin
    base_res   = '0;
    base_ovf   = 1'b0;
    base_carry = 1'b0;
    base_ill   = 1'b0;
    case (op_in)
      ALU_ADD: begin
        base_res   = add_sum[WIDTH-1:0];
        base_carry = add_sum[WIDTH];
        base_ovf   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != operand1[WIDTH-1]);
      end
      ALU_SUB: begin
        base_res   = sub_diff;
        base_carry = operand1 < operand2;
        base_ovf   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                     (sub_diff[WIDTH-1] != operand1[WIDTH-1]);
      end
      ALU_SLL:  base_res = operand1 << shamt;
      ALU_SLT:  base_res = {{(WIDTH-1){1'b0}}, $signed(operand1) < $signed(operand2)};
      ALU_SLTU: base_res = {{(WIDTH-1){1'b0}}, operand1 < operand2};
      ALU_XOR:  base_res = operand1 ^ operand2;
      ALU_SRL:  base_res = operand1 >> shamt;
      ALU_SRA:  base_res = $signed(operand1) >>> shamt;
      ALU_OR:   base_res = operand1 | operand2;
      ALU_AND:  base_res = operand1 & operand2;
      default:  base_ill = 1'b1;
    endcase
  end

  alu_mul_pipe #(
    .WIDTH      (WIDTH),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (go_mul),
    .a_signed  ((op_in == ALU_MULH) || (op_in == ALU_MULHSU)),
    .b_signed  (op_in == ALU_MULH),
    .hi        (op_in != ALU_MUL),
    .a         (operand1),
    .b         (operand2),
    .out_valid (mul_valid),
    .result    (mul_res)
  );

`ifdef ALU_DIV_EN
  localparam int CW = $clog2(WIDTH + 1);

  alu_op_t          op_q;
  logic [WIDTH-1:0] op1_q, op2_q, div_rem, div_quo, div_den;
  logic [CW-1:0]    div_cnt;
  logic [WIDTH:0]   div_trial;
  logic             in_sgn, sgn_q, q_neg, r_neg, rem_q;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign go_div    = accept && is_div(op_in);
  assign in_sgn    = (op_in == ALU_DIV) || (op_in == ALU_REM);
  assign div_trial = {div_rem, div_quo[WIDTH-1]} - {1'b0, div_den};
  assign div_done  = (state == ST_DIV) && (div_cnt == '0);

  // Load magnitudes on accept, then one restoring step per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      op_q    <= ALU_ADD;
      op1_q   <= '0;
      op2_q   <= '0;
      div_rem <= '0;
      div_quo <= '0;
      div_den <= '0;
    end else if (go_div) begin
      op_q    <= op_in;
      op1_q   <= operand1;
      op2_q   <= operand2;
      div_rem <= '0;
      div_quo <= (in_sgn && operand1[WIDTH-1]) ? -operand1 : operand1;
      div_den <= (in_sgn && operand2[WIDTH-1]) ? -operand2 : operand2;
      div_cnt <= CW'(WIDTH);
    end else if ((state == ST_DIV) && (div_cnt != '0)) begin
      div_cnt <= div_cnt - 1'b1;
      if (!div_trial[WIDTH]) begin
        div_rem <= div_trial[WIDTH-1:0];
        div_quo <= {div_quo[WIDTH-2:0], 1'b1};
      end else begin
        div_rem <= {div_rem[WIDTH-2:0], div_quo[WIDTH-1]};
        div_quo <= {div_quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fix; divide-by-zero bypasses the iteration result entirely.
  assign sgn_q = (op_q == ALU_DIV) || (op_q == ALU_REM);
  assign rem_q = (op_q == ALU_REM) || (op_q == ALU_REMU);
  assign q_neg = sgn_q && (op1_q[WIDTH-1] ^ op2_q[WIDTH-1]);
  assign r_neg = sgn_q && op1_q[WIDTH-1];
  assign q_fix = q_neg ? -div_quo : div_quo;
  assign r_fix = r_neg ? -div_rem : div_rem;
  assign div_res = (op2_q == '0) ? (rem_q ? op1_q : '1)
                                 : (rem_q ? r_fix : q_fix);
`else
  assign go_div   = 1'b0;
  assign div_done = 1'b0;
  assign div_res  = '0;
`endif

  // Select which path writes the result register this cycle.
  always_comb begin
    load_res = 1'b0;
    res_d    = base_res;
    ovf_d    = base_ovf;
    carry_d  = base_carry;
    ill_d    = base_ill;
    if (mul_valid) begin
      load_res = 1'b1;
      res_d    = mul_res;
      ovf_d    = 1'b0;
      carry_d  = 1'b0;
      ill_d    = 1'b0;
    end else if (div_done) begin
      load_res = 1'b1;
      res_d    = div_res;
      ovf_d    = 1'b0;
      carry_d  = 1'b0;
      ill_d    = 1'b0;
    end else if (accept && !go_mul && !go_div) begin
      load_res = 1'b1;
    end
  end

  // Result and flags are registered together and held through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result <= '0;
      zero       <= 1'b0;
      negative   <= 1'b0;
      overflow   <= 1'b0;
      carry      <= 1'b0;
      illegal    <= 1'b0;
    end else if (load_res) begin
      alu_result <= res_d;
      zero       <= (res_d == '0);
      negative   <= res_d[WIDTH-1];
      overflow   <= ovf_d;
      carry      <= carry_d;
      illegal    <= ill_d;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (go_mul)      state_nx = (MUL_STAGES == 1) ? ST_DONE : ST_MUL;
          else if (go_div) state_nx = ST_DIV;
          else             state_nx = ST_DONE;
        end else if ((state == ST_DONE) && out_ready) begin
          state_nx = ST_IDLE;
        end
      end
      ST_MUL:  if (mul_valid) state_nx = ST_DONE;
      ST_DIV:  if (div_done)  state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
